// File: rtl/lsu_bus_bridge_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_bus_bridge_pkg : access-size encodings and bridge FSM states | rev 1.0
// ---------------------------------------------------------------------------
package lsu_bus_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_lane_align : byte-lane enables, store replication, load shift | rev 1.0
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shifted,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (byte_sel)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // The addressed byte lane is brought down to bit 0 for the core's extender.
  assign rdata_shifted = rdata >> {addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_bus_bridge : core data port to single-outstanding req/gnt bus | rev 1.0
// ---------------------------------------------------------------------------
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr_i,
  input  logic [1:0]  cpu_byte_sel_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic        cpu_re_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        mis;
  logic        go;
  logic        is_load;
  logic        timeout_hit;
  logic [31:0] rdata_shifted;

  lsu_lane_align u_align (
    .addr_lo       (cpu_addr_i[1:0]),
    .byte_sel      (cpu_byte_sel_i),
    .wdata         (cpu_wdata_i),
    .rdata         (bus_rdata_i),
    .be            (bus_be_o),
    .wdata_rep     (bus_wdata_o),
    .rdata_shifted (rdata_shifted),
    .misaligned    (mis)
  );

  assign go          = (cpu_we_i | cpu_re_i) & ~mis;
  assign is_load     = cpu_re_i & ~cpu_we_i;
  // Counter may sit at TIMEOUT after a last-cycle grant, hence >=.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  assign bus_addr_o   = {cpu_addr_i[31:2], 2'b00};
  assign bus_we_o     = cpu_we_i;
  assign misaligned_o = mis;
  assign bus_err_o    = err_q;
  assign stall_o      = go & (state_q != DONE);
  assign cpu_rdata_o  = (state_q == DONE) ? rdata_q : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    bus_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus_req_o = go;
        cnt_d     = '0;
        if (go) state_d = bus_gnt_i ? RESP : REQ;
      end
      REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus_rvalid_i) begin
          if (is_load) rdata_d = rdata_shifted;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu_bus_bridge : directed vector bench for lsu_bus_bridge | rev 1.0
// ---------------------------------------------------------------------------
module tb_lsu_bus_bridge;
  import lsu_bus_bridge_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mis;
  logic        err;
  logic        req;
  logic        bwe;
  logic [31:0] baddr;
  logic [3:0]  be;
  logic [31:0] bwdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] brdata;

  int checks = 0;
  int errors = 0;

  lsu_bus_bridge #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_addr_i     (cpu_addr),
    .cpu_byte_sel_i (cpu_sel),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_we_i       (cpu_we),
    .cpu_re_i       (cpu_re),
    .cpu_rdata_o    (cpu_rdata),
    .stall_o        (stall),
    .misaligned_o   (mis),
    .bus_err_o      (err),
    .bus_req_o      (req),
    .bus_we_o       (bwe),
    .bus_addr_o     (baddr),
    .bus_be_o       (be),
    .bus_wdata_o    (bwdata),
    .bus_gnt_i      (gnt),
    .bus_rvalid_i   (rvalid),
    .bus_rdata_i    (brdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic        exp_mis;
    logic [31:0] exp_cpu;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                       input logic we, input logic re);
    cpu_addr  = a;
    cpu_sel   = s;
    cpu_wdata = w;
    cpu_we    = we;
    cpu_re    = re;
  endtask

  initial begin
    //          addr          sel      wdata         we    re    rdata         be       wdata_rep     bus addr      mis   cpu in DONE
    tbl[0] = '{32'h0000_1000, SZ_WORD, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0,        32'h0000_1000, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{32'h0000_3002, SZ_HALF, 32'h0,        1'b0, 1'b1, 32'h1234ABCD, 4'b1100, 32'h0,        32'h0000_3000, 1'b0, 32'h00001234};
    tbl[2] = '{32'h0000_2001, SZ_BYTE, 32'h0,        1'b0, 1'b1, 32'h11223344, 4'b0010, 32'h0,        32'h0000_2000, 1'b0, 32'h00112233};
    tbl[3] = '{32'h0000_5000, SZ_HALF, 32'h0000BEEF, 1'b1, 1'b0, 32'h0,        4'b0011, 32'hBEEFBEEF, 32'h0000_5000, 1'b0, 32'h00112233};
    tbl[4] = '{32'h0000_6004, SZ_WORD, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0000_6004, 1'b0, 32'h00112233};
    tbl[5] = '{32'h0000_7002, SZ_BYTE, 32'h0000003C, 1'b1, 1'b0, 32'h0,        4'b0100, 32'h3C3C3C3C, 32'h0000_7000, 1'b0, 32'h00112233};
    tbl[6] = '{32'h0000_8000, SZ_WORD, 32'h01020304, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, 32'h01020304, 32'h0000_8000, 1'b0, 32'h00112233};
    tbl[7] = '{32'h0000_4001, SZ_WORD, 32'h0,        1'b0, 1'b1, 32'h0,        4'b1111, 32'h0,        32'h0000_4000, 1'b1, 32'h0};
    tbl[8] = '{32'h0000_4003, SZ_HALF, 32'h00001234, 1'b1, 1'b0, 32'h0,        4'b1100, 32'h12341234, 32'h0000_4000, 1'b1, 32'h0};
    tbl[9] = '{32'h0000_4000, 2'b11,   32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0000_4000, 1'b1, 32'h0};

    rst_n  = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    brdata = 32'h0;
    drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_req",   req,       1'b0);
    chk("rst_stall", stall,     1'b0);
    chk("rst_err",   err,       1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      drive(tbl[i].addr, tbl[i].sel, tbl[i].wdata, tbl[i].we, tbl[i].re);
      gnt = 1'b1;
      #1;
      chk($sformatf("v%0d_mis", i), mis, tbl[i].exp_mis);
      if (tbl[i].exp_mis) begin
        chk($sformatf("v%0d_req", i),   req,       1'b0);
        chk($sformatf("v%0d_stall", i), stall,     1'b0);
        chk($sformatf("v%0d_rdata", i), cpu_rdata, 32'h0);
        tick();
        gnt = 1'b0;
        #1;
        chk($sformatf("v%0d_req_hold", i), req, 1'b0);
      end else begin
        chk($sformatf("v%0d_req", i),   req,    1'b1);
        chk($sformatf("v%0d_be", i),    be,     tbl[i].exp_be);
        chk($sformatf("v%0d_wdata", i), bwdata, tbl[i].exp_wdata);
        chk($sformatf("v%0d_addr", i),  baddr,  tbl[i].exp_addr);
        chk($sformatf("v%0d_we", i),    bwe,    tbl[i].we);
        chk($sformatf("v%0d_stall0", i), stall, 1'b1);
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        brdata = tbl[i].rdata;
        #1;
        chk($sformatf("v%0d_resp_req", i), req,   1'b0);
        chk($sformatf("v%0d_stall1", i),   stall, 1'b1);
        tick();
        rvalid = 1'b0;
        brdata = 32'h0;
        #1;
        chk($sformatf("v%0d_done_stall", i), stall,     1'b0);
        chk($sformatf("v%0d_done_rdata", i), cpu_rdata, tbl[i].exp_cpu);
      end
      tick();
      drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);
      #1;
      chk($sformatf("v%0d_idle_stall", i), stall, 1'b0);
    end

    // Byte store held in REQ until a late grant.
    tick();
    drive(32'h0000_2003, SZ_BYTE, 32'h0000_00A5, 1'b1, 1'b0);
    gnt = 1'b0;
    #1;
    chk("bs_req",   req,    1'b1);
    chk("bs_be",    be,     4'b1000);
    chk("bs_wdata", bwdata, 32'hA5A5A5A5);
    chk("bs_we",    bwe,    1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      chk($sformatf("bs_hold%0d_req", k),   req,    1'b1);
      chk($sformatf("bs_hold%0d_be", k),    be,     4'b1000);
      chk($sformatf("bs_hold%0d_addr", k),  baddr,  32'h0000_2000);
      chk($sformatf("bs_hold%0d_stall", k), stall,  1'b1);
    end
    tick();
    gnt = 1'b1;
    #1;
    chk("bs_gnt_req", req, 1'b1);
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    #1;
    chk("bs_resp_req",   req,   1'b0);
    chk("bs_resp_stall", stall, 1'b1);
    tick();
    rvalid = 1'b0;
    #1;
    chk("bs_done_stall", stall,     1'b0);
    chk("bs_done_rdata", cpu_rdata, 32'h00112233);
    chk("bs_done_err",   err,       1'b0);
    tick();
    drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);

    // Timeout: grant given, response withheld for four cycles.
    tick();
    drive(32'h0000_9000, SZ_WORD, 32'h0, 1'b0, 1'b1);
    gnt = 1'b1;
    #1;
    chk("to_req", req, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      gnt = 1'b0;
      #1;
      chk($sformatf("to_wait%0d_stall", k), stall, 1'b1);
      chk($sformatf("to_wait%0d_err", k),   err,   1'b0);
    end
    tick();
    #1;
    chk("to_err",   err,       1'b1);
    chk("to_stall", stall,     1'b0);
    chk("to_rdata", cpu_rdata, 32'h0);
    tick();
    drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);
    #1;
    chk("to_err_clear", err, 1'b0);
    tick();
    rvalid = 1'b1;
    brdata = 32'h5555_5555;
    #1;
    chk("to_late_req",   req,   1'b0);
    chk("to_late_stall", stall, 1'b0);
    tick();
    rvalid = 1'b0;
    brdata = 32'h0;
    #1;
    chk("to_late_rdata", cpu_rdata, 32'h0);

    // Reset while waiting in RESP.
    tick();
    drive(32'h0000_A000, SZ_WORD, 32'h0, 1'b0, 1'b1);
    gnt = 1'b1;
    #1;
    chk("rr_req", req, 1'b1);
    tick();
    gnt = 1'b0;
    #1;
    chk("rr_resp_stall", stall, 1'b1);
    tick();
    rst_n = 1'b0;
    drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rr_rst_req",   req,       1'b0);
    chk("rr_rst_stall", stall,     1'b0);
    chk("rr_rst_rdata", cpu_rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(32'h0000_B000, SZ_WORD, 32'h0, 1'b0, 1'b1);
    rvalid = 1'b1;
    brdata = 32'h7777_7777;
    #1;
    chk("rr_new_req",   req,   1'b1);
    chk("rr_new_stall", stall, 1'b1);
    tick();
    rvalid = 1'b0;
    brdata = 32'h0;
    gnt    = 1'b1;
    #1;
    chk("rr_req_wait", req, 1'b1);
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    brdata = 32'h1357_9BDF;
    #1;
    chk("rr_resp_req", req, 1'b0);
    tick();
    rvalid = 1'b0;
    brdata = 32'h0;
    #1;
    chk("rr_done_stall", stall,     1'b0);
    chk("rr_done_rdata", cpu_rdata, 32'h1357_9BDF);
    tick();
    drive(32'h0, SZ_BYTE, 32'h0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
